fetch_controller: RTL and testbench

Sequencing and arbitration controller for the synchronous-read instruction memory in the IF stage. It owns the program counter and issues fetch addresses. It absorbs the memory's one-cycle read latency with a 2-entry output buffer so downstream stalls never lose an instruction. It also shares the memory read port with a debug/loader read requester.

---
 rtl/fetch_controller.sv | 181 ++++++++++++++++++
 tb/tb_fetch_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: owns the IF-stage program counter, issues fetch addresses to
// a synchronous-read instruction memory, buffers responses in a 2-entry FIFO and
// shares the memory read port with a debug/loader read requester.
module fetch_controller #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_grant,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_DEBUG} tag_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  tag_t                  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] tag_pc_q, tag_pc_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [ADDR_WIDTH-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  dbg_rvalid_q, dbg_rvalid_d;

  logic                  pop_c, push_c, resp_fetch_c, credit_c, fetch_ok_c, grant_c;
  logic [2:0]            need_c, room_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;

  // Next-state, port arbitration, response routing and FIFO update
  always_comb begin
    state_d      = state_q;
    tag_d        = TAG_NONE;
    pc_d         = pc_q;
    tag_pc_d     = tag_pc_q;
    cnt_d        = cnt_q;
    e0_data_d    = e0_data_q;
    e0_pc_d      = e0_pc_q;
    e1_data_d    = e1_data_q;
    e1_pc_d      = e1_pc_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_rvalid_d = 1'b0;
    grant_c      = 1'b0;
    mem_addr_c   = addr_q;

    pop_c        = (cnt_q != 2'd0) && !stall;
    resp_fetch_c = (tag_q == TAG_FETCH);
    // A fetch response arriving in a redirect cycle belongs to the old stream.
    push_c       = resp_fetch_c && !redirect;

    // Entries held + response in flight - entry leaving must leave room for one more.
    need_c   = {1'b0, cnt_q} + {2'b00, resp_fetch_c};
    room_c   = 3'd1 + {2'b00, pop_c};
    credit_c = (need_c <= room_c);

    if (redirect) begin
      state_d = RUN;
    end else if (state_q == IDLE && enable) begin
      state_d = RUN;
    end else if (state_q == RUN && !enable) begin
      state_d = IDLE;
    end

    // The cycle that moves IDLE->RUN already issues, so fetch starts with enable.
    fetch_ok_c = (state_d == RUN) && enable && credit_c;

    if (redirect) begin
      mem_addr_c = redirect_pc;
      pc_d       = redirect_pc + PC_STEP;
      tag_d      = TAG_FETCH;
      tag_pc_d   = redirect_pc;
    end else if (dbg_req) begin
      grant_c    = 1'b1;
      mem_addr_c = dbg_addr;
      tag_d      = TAG_DEBUG;
    end else if (fetch_ok_c) begin
      mem_addr_c = pc_q;
      pc_d       = pc_q + PC_STEP;
      tag_d      = TAG_FETCH;
      tag_pc_d   = pc_q;
    end

    if (tag_q == TAG_DEBUG) begin
      dbg_rdata_d  = mem_data;
      dbg_rvalid_d = 1'b1;
    end

    if (redirect) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_c, pop_c})
        2'b01: begin
          e0_data_d = e1_data_q;
          e0_pc_d   = e1_pc_q;
          cnt_d     = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_data_d = mem_data;
            e0_pc_d   = tag_pc_q;
          end else begin
            e1_data_d = mem_data;
            e1_pc_d   = tag_pc_q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_data_d = mem_data;
            e0_pc_d   = tag_pc_q;
          end else begin
            e0_data_d = e1_data_q;
            e0_pc_d   = e1_pc_q;
            e1_data_d = mem_data;
            e1_pc_d   = tag_pc_q;
          end
        end
        default: ;
      endcase
    end

    addr_d = mem_addr_c;
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      tag_q        <= TAG_NONE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      tag_pc_q     <= '0;
      cnt_q        <= 2'd0;
      e0_data_q    <= '0;
      e0_pc_q      <= '0;
      e1_data_q    <= '0;
      e1_pc_q      <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      tag_pc_q     <= tag_pc_d;
      cnt_q        <= cnt_d;
      e0_data_q    <= e0_data_d;
      e0_pc_q      <= e0_pc_d;
      e1_data_q    <= e1_data_d;
      e1_pc_q      <= e1_pc_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign dbg_grant   = grant_c && !reset;
  assign mem_address = reset ? RESET_PC : mem_addr_c;
  assign dbg_rdata   = dbg_rdata_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign instr       = e0_data_q;
  assign instr_pc    = e0_pc_q;
  assign instr_valid = (cnt_q != 2'd0);

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_fetch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, stall = 1'b0, redirect = 1'b0, dbg_req = 1'b0;
  logic [31:0] redirect_pc = '0, dbg_addr = '0;
  logic        dbg_grant, dbg_rvalid, instr_valid;
  logic [31:0] dbg_rdata, mem_address, mem_data, instr, instr_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Memory: word n holds n + 0x100, one-cycle read latency
  always @(posedge clock) mem_data <= mem_address + 32'h100;

  fetch_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_grant(dbg_grant),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_address(mem_address), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  typedef struct {
    logic rs, en, st, rd; logic [31:0] rpc; logic dq; logic [31:0] da;
    logic ev; logic [31:0] epc; logic eg; logic [31:0] ea; logic erv; logic [31:0] erd;
  } vec_t;
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;

  vec_t tbl[$];
  ent_t mq[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge
  task automatic drive(input logic rs, en, st, rd, input logic [31:0] rpc,
                       input logic dq, input logic [31:0] da);
    @(posedge clock); #1;
    reset = rs; enable = en; stall = st; redirect = rd;
    redirect_pc = rpc; dbg_req = dq; dbg_addr = da;
    @(negedge clock);
  endtask

  task automatic add(input logic rs, en, st, rd, input logic [31:0] rpc, input logic dq,
                     input logic [31:0] da, input logic ev, input logic [31:0] epc,
                     input logic eg, input logic [31:0] ea, input logic erv,
                     input logic [31:0] erd);
    vec_t v;
    v.rs = rs; v.en = en; v.st = st; v.rd = rd; v.rpc = rpc; v.dq = dq; v.da = da;
    v.ev = ev; v.epc = epc; v.eg = eg; v.ea = ea; v.erv = erv; v.erd = erd;
    tbl.push_back(v);
  endtask

  // Random-phase stimulus and model state
  logic        r_rs, r_en, r_st, r_rd, r_dq, m_pop, m_grant, m_fetch, m_rvalid, dbg_pend;
  logic [31:0] r_rpc, r_da, exp_addr, m_pc, m_addr, m_inf, m_rdata, resp;
  int          m_kind, m_need, stall_left;
  ent_t        e;

  initial begin
    //  rs en st rd rpc     dq da     | ev epc     eg ea      erv erd
    add(1, 0, 0, 0, 0,      0, 0,       0, 0,      0, 0,      0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       0, 0,      0, 0,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       0, 0,      0, 0,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       0, 0,      0, 1,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 0,      0, 2,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 1,      0, 3,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 2,      0, 4,      0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 1, 0, 0,    0, 0,       1, 3,      0, 4,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 3,      0, 5,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 4,      0, 6,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 5,      0, 7,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 6,      0, 8,      0, 0);
    add(0, 1, 1, 0, 0,      0, 0,       1, 7,      0, 8,      0, 0);
    add(0, 1, 1, 1, 'h40,   0, 0,       1, 7,      0, 'h40,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       0, 0,      0, 'h41,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h40,   0, 'h42,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h41,   0, 'h43,   0, 0);
    add(0, 1, 0, 0, 0,      1, 7,       1, 'h42,   1, 7,      0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h43,   0, 'h44,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       0, 0,      0, 'h45,   1, 'h107);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h44,   0, 'h46,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h45,   0, 'h47,   0, 0);
    add(0, 1, 0, 1, 'h80,   1, 'h20,    1, 'h46,   0, 'h80,   0, 0);
    add(0, 1, 0, 0, 0,      1, 'h20,    0, 0,      1, 'h20,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h80,   0, 'h81,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       0, 0,      0, 'h82,   1, 'h120);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h81,   0, 'h83,   0, 0);
    add(0, 1, 0, 0, 0,      0, 0,       1, 'h82,   0, 'h84,   0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       1, 'h83,   0, 'h84,   0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       1, 'h84,   0, 'h84,   0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       0, 0,      0, 'h84,   0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].en, tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].dq, tbl[i].da);
      chk($sformatf("v%0d_valid", i), instr_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), instr_pc, tbl[i].epc);
        chk($sformatf("v%0d_instr", i), instr, memw(tbl[i].epc));
      end
      chk($sformatf("v%0d_grant", i), dbg_grant, tbl[i].eg);
      chk($sformatf("v%0d_addr", i), mem_address, tbl[i].ea);
      chk($sformatf("v%0d_rvalid", i), dbg_rvalid, tbl[i].erv);
      if (tbl[i].erv) chk($sformatf("v%0d_rdata", i), dbg_rdata, tbl[i].erd);
      if (tbl[i].rs) begin
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
      end
    end

    // PC wrap at the top of the address space
    drive(0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("wrap_addr0", mem_address, 32'hFFFF_FFFF);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_valid0", instr_valid, 0);
    chk("wrap_addr1", mem_address, 32'h0);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFF);
    chk("wrap_instr_top", instr, 32'h0000_00FF);
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("wrap_valid_zero", instr_valid, 1);
    chk("wrap_pc_zero", instr_pc, 32'h0);
    chk("wrap_instr_zero", instr, 32'h100);

    // Reset with a fetch in flight, after a debug read left dbg_rdata nonzero
    drive(0, 1, 0, 0, 0, 1, 5);
    chk("rif_grant", dbg_grant, 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 9);
    chk("rif_rvalid", dbg_rvalid, 1);
    chk("rif_rdata", dbg_rdata, 32'h105);
    chk("rif_grant_in_reset", dbg_grant, 0);
    chk("rif_addr_in_reset", mem_address, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rif_valid_after", instr_valid, 0);
    chk("rif_rvalid_after", dbg_rvalid, 0);
    chk("rif_instr_after", instr, 0);
    chk("rif_pc_after", instr_pc, 0);
    chk("rif_rdata_after", dbg_rdata, 0);
    chk("rif_addr_after", mem_address, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rif_valid_later", instr_valid, 0);
    chk("rif_rvalid_later", dbg_rvalid, 0);

    // Randomized traffic against the reference model
    drive(1, 0, 0, 0, 0, 0, 0);
    mq.delete(); m_kind = 0; m_inf = 0; m_pc = 0; m_addr = 0; m_rdata = 0; m_rvalid = 0;
    dbg_pend = 0; stall_left = 0; r_da = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rs = ($urandom_range(0, 199) == 0);
      r_en = ($urandom_range(0, 9) != 0);
      if (stall_left > 0) begin
        r_st = 1; stall_left--;
      end else begin
        r_st = 0;
        if ($urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 6);
      end
      r_rd  = ($urandom_range(0, 15) == 0);
      r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2)))
                                           : $urandom;
      if (dbg_pend) r_dq = 1;
      else begin
        r_dq = ($urandom_range(0, 9) == 0);
        r_da = $urandom;
      end

      m_pop   = (mq.size() > 0) && !r_st;
      m_grant = r_dq && !r_rd && !r_rs;
      m_need  = mq.size() + ((m_kind == 1) ? 1 : 0) - (m_pop ? 1 : 0);
      m_fetch = r_en && !r_rd && !m_grant && (m_need <= 1);
      exp_addr = r_rs ? 32'h0 : r_rd ? r_rpc : m_grant ? r_da : m_fetch ? m_pc : m_addr;

      drive(r_rs, r_en, r_st, r_rd, r_rpc, r_dq, r_da);
      chk("rnd_valid", instr_valid, (mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rnd_pc", instr_pc, mq[0].pc);
        chk("rnd_instr", instr, mq[0].d);
      end
      chk("rnd_grant", dbg_grant, m_grant);
      chk("rnd_addr", mem_address, exp_addr);
      chk("rnd_rvalid", dbg_rvalid, m_rvalid);
      chk("rnd_rdata", dbg_rdata, m_rdata);

      if (r_rs) begin
        mq.delete(); m_kind = 0; m_inf = 0; m_pc = 0; m_addr = 0;
        m_rdata = 0; m_rvalid = 0; dbg_pend = 0;
      end else begin
        resp     = memw(m_inf);
        m_rvalid = (m_kind == 2);
        if (m_rvalid) m_rdata = resp;
        if (m_pop) e = mq.pop_front();
        if (m_kind == 1 && !r_rd) begin
          e.d = resp; e.pc = m_inf;
          mq.push_back(e);
        end
        if (r_rd) mq.delete();
        if (r_rd) begin
          m_kind = 1; m_inf = r_rpc; m_pc = r_rpc + 32'h1;
        end else if (m_grant) begin
          m_kind = 2; m_inf = r_da;
        end else if (m_fetch) begin
          m_kind = 1; m_inf = m_pc; m_pc = m_pc + 32'h1;
        end else begin
          m_kind = 0;
        end
        m_addr   = exp_addr;
        dbg_pend = r_dq && !m_grant;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
